// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: stage indices, default parameters and the stage vector type for the pipeline hazard controller.
package pipe_ctrl_pkg;
  localparam int STG_PC = 0;
  localparam int STG_IF = 1;
  localparam int STG_ID = 2;
  localparam int STG_EX = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB = 5;
  localparam int NUM_STAGES_DEF = 6;
  localparam int STALL_TIMEOUT_DEF = 1024;
  typedef logic [NUM_STAGES_DEF-1:0] stage_vec_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: stall/flush/watchdog bundle; perf_cnt_o exists only with PIPE_PERF_CNT_EN.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 6,
  parameter int CNT_W = 32
);
  logic [NUM_STAGES-1:0] stall_req;
  logic [NUM_STAGES-1:0] flush_req;
  logic [NUM_STAGES-1:0] stall_o;
  logic [NUM_STAGES-2:0] bubble_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic timeout_o;
  logic timeout_clr;
  if (CNT_W < 1) begin : g_chk
    $error("CNT_W must be at least 1");
  end
`ifdef PIPE_PERF_CNT_EN
  logic [NUM_STAGES*CNT_W-1:0] perf_cnt_o;
  modport master(output stall_req, flush_req, timeout_clr,
                 input stall_o, bubble_o, flush_o, timeout_o, perf_cnt_o);
  modport slave(input stall_req, flush_req, timeout_clr,
                output stall_o, bubble_o, flush_o, timeout_o, perf_cnt_o);
`else
  modport master(output stall_req, flush_req, timeout_clr,
                 input stall_o, bubble_o, flush_o, timeout_o);
  modport slave(input stall_req, flush_req, timeout_clr,
                output stall_o, bubble_o, flush_o, timeout_o);
`endif
endinterface

// File: rtl/pipe_hazard_ctrl_watchdog.sv
// pipe_stall_watchdog: saturating consecutive-stall counter with a sticky timeout flag; clear beats set.
module pipe_stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalling,
  input  logic clr,
  output logic timeout
);
  localparam int W = $clog2(STALL_TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= !stalling ? '0 : (cnt == W'(STALL_TIMEOUT)) ? cnt : cnt + 1'b1;
      if (stalling && cnt >= W'(STALL_TIMEOUT - 1)) timeout <= 1'b1;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: thermometer stall merge, bubble strobes, deferred flush sequencing and stall watchdog; PIPE_PERF_CNT_EN adds per-stage stall counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int N = NUM_STAGES;
  logic [N-1:0] raw, frz, eff, fo, so, pend;
  logic timeout;
  if (N < 2 || STALL_TIMEOUT < 2 || CNT_W < 1) begin : g_chk
    $error("pipe_hazard_ctrl: bad parameters");
  end
  always_comb begin
    raw = '0;
    frz = '0;
    fo = '0;
    raw[N-1] = bus.stall_req[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      raw[i] = raw[i+1] | bus.stall_req[i];
      frz[i] = raw[i+1];
    end
    eff = (bus.flush_req | pend) & ~frz;
    eff[0] = 1'b0;
    for (int i = N - 2; i >= 0; i--) fo[i] = fo[i+1] | eff[i+1];
    so = raw & ~fo;
  end
  // a flush blocked by an older stall waits here until that stage unfreezes
  always_ff @(posedge clk)
    pend <= rst ? '0 : ((pend | bus.flush_req) & ~eff) & {{(N-1){1'b1}}, 1'b0};
  assign bus.stall_o = rst ? '0 : so;
  assign bus.flush_o = rst ? '0 : fo;
  assign bus.bubble_o = rst ? '0 : so[N-2:0] & ~so[N-1:1] & ~fo[N-2:0];
  assign bus.timeout_o = timeout;
  pipe_stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .stalling(|bus.stall_o),
    .clr(bus.timeout_clr),
    .timeout(timeout)
  );
`ifdef PIPE_PERF_CNT_EN
  for (genvar g = 0; g < N; g++) begin : g_perf
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) cnt <= rst ? '0 : cnt + CNT_W'(bus.stall_o[g]);
    assign bus.perf_cnt_o[g*CNT_W +: CNT_W] = cnt;
  end
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller for an N-stage in-order core. Stage index 0 is the youngest stage (PC), index NUM_STAGES-1 the oldest (WB). It merges per-stage stall requests into a thermometer stall vector, generates bubble-insert strobes, and sequences flush requests, deferring them while the requesting stage is frozen. It also provides a stall watchdog for bus/cache lockups. It sits beside the pipeline registers and replaces the fixed 6-bit priority stall encoder.

Parameters:
NUM_STAGES, 6, number of pipeline stages (>=2)
STALL_TIMEOUT, 1024, consecutive stalled cycles before the watchdog fires (>=2)
CNT_W, 32, width of each optional performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
stall_req  in  NUM_STAGES  stall_req[i]=1: stage i cannot complete this cycle
flush_req  in  NUM_STAGES  single-cycle pulse; flush_req[j] kills all instructions younger than stage j; bit 0 ignored
stall_o  out  NUM_STAGES  stall_o[i]=1: stage i pipeline register holds
bubble_o  out  NUM_STAGES-1  bubble_o[i]=1: register after stage i loads a NOP
flush_o  out  NUM_STAGES  flush_o[i]=1: register after stage i loads a NOP (flush)
timeout_o  out  1  sticky watchdog flag
timeout_clr  in  1  clears timeout_o and the watchdog counter
perf_cnt_o  out  NUM_STAGES*CNT_W  per-stage stall-cycle counters; present only with PIPE_PERF_CNT_EN

Behaviour:
- While rst=1: stall_o, bubble_o and flush_o are 0, regardless of inputs. Reset also clears timeout_o, the watchdog counter, pend_flush and perf counters.
- Thermometer: raw_stall[i] = OR of stall_req[k] for k>=i. stall_req[3] gives 000...1111.
- frozen(j) = OR of stall_req[k] for k>j, i.e. an older stage blocks stage j.
- Flush combinational path (zero latency): eff[j] = (flush_req[j] | pend_flush[j]) & ~frozen(j), for j>=1. flush_o[i] = OR of eff[j] over j>i.
- pend_flush register: next = (pend_flush | flush_req) & ~eff.
  - A flush issued while frozen is emitted in the first cycle its stage unfreezes, then cleared.
  - Repeated requests for the same j merge.
  - Several pending flushes are emitted together when unfrozen; the resulting mask is the union.
- Priority: stall_o = raw_stall & ~flush_o. Flush overrides stall for killed registers.
- bubble_o[i] = stall_o[i] & ~stall_o[i+1] & ~flush_o[i]. The oldest stalled boundary passes a NOP downstream.
- Watchdog:
  - stall_cnt increments in each cycle where stall_o != 0.
  - It resets to 0 on any cycle with stall_o == 0, and saturates at STALL_TIMEOUT.
  - timeout_o sets on the cycle after stall_cnt reaches STALL_TIMEOUT-1 while still stalled, and stays set.
  - timeout_clr clears timeout_o and stall_cnt. If clear coincides with set, clear wins.
- Outputs are combinational from inputs plus registered state. There are no combinational loops; flush_req never feeds stall_req internally.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: perf_cnt_o[i] increments each cycle stall_o[i]=1, wrapping at 2^CNT_W. It is cleared by rst.
- Undefined: the port is absent and no counter flops are generated.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - stage index constants STG_PC=0, STG_IF=1, STG_ID=2, STG_EX=3, STG_MEM=4, STG_WB=5
  - defaults NUM_STAGES_DEF=6, STALL_TIMEOUT_DEF=1024
  - typedef stage_vec_t
- One sub-module, pipe_stall_watchdog, contains the counter plus sticky flag (inputs: stalling, clr; output: timeout).

Test Plan:
- Reset mid-operation: stall_req=6'b010000 for 3 cycles, pending flush set, then rst=1 for 1 cycle -> all outputs 0 next cycle; pend_flush cleared, no late flush.
- Thermometer and bubble: stall_req=6'b000100 -> stall_o=6'b000111, bubble_o=5'b00100. Then stall_req=6'b010001 -> stall_o=6'b011111, bubble_o=5'b10000.
- Immediate flush: flush_req=6'b001000, stall_req=6'b000100 -> flush_o=6'b000111, stall_o=6'b000000 the same cycle.
- Deferred flush: flush_req[3] pulse while stall_req[4]=1 for 4 cycles -> flush_o=0 during the stall; flush_o=6'b000111 for exactly 1 cycle when stall_req[4] drops, then 0.
- Watchdog (STALL_TIMEOUT=8): stall_req[0] held -> timeout_o=1 from cycle 9 onward. A gap cycle at cycle 5 restarts the count. timeout_clr and the setting condition on the same cycle -> timeout_o=0.
- PIPE_PERF_CNT_EN defined: stall_req=6'b000010 for 10 cycles -> perf_cnt[0]=perf_cnt[1]=10, others 0. Counter preset near 2^CNT_W-1 wraps to 0.
